// File: rtl/ra_pq_regarray.sv
// Register-array priority queue: DEPTH sorted key-value slots with per-slot
// hold / neighbour-shift / load select, minimum key always at slot 0.
package pq_pkg;
    localparam int KW = 8;
    localparam int VW = 8;
    typedef struct packed {
        logic [KW-1:0] key;
        logic [VW-1:0] value;
    } kv_t;
endpackage

module ra_pq_regarray
    import pq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq,
    input  kv_t                        kvi,
    input  logic                       deq,
    output kv_t                        kvo,
    output logic                       kvo_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf,
    output logic                       udf
);
    localparam int CW = $clog2(DEPTH+1);

    kv_t              slot   [DEPTH];
    kv_t              slot_d [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_d;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;
    logic             udf_q;

    // Thermometer compare vectors: ins_ge marks slots at/after the insertion
    // point, rep_lt marks slots that shift left on a head replace.
    logic [DEPTH-1:0] ins_ge;
    logic [DEPTH-1:0] ins_at;
    logic [DEPTH-1:0] rep_lt;
    logic [DEPTH-1:0] rep_at;

    logic is_empty;
    logic is_full;
    logic deq_ok;
    logic do_ins;
    logic do_del;
    logic do_rep;

    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CW'(DEPTH));
    assign deq_ok   = deq && !is_empty;
    assign do_ins   = enq && !deq_ok && !is_full;
    assign do_del   = deq_ok && !enq;
    assign do_rep   = enq && deq_ok;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        kv_t        nb_r;
        kv_t        nb_l;
        logic       nb_r_v;
        logic       nb_l_v;
        logic [1:0] sel;
        logic       dir_left;
        kv_t        d1;
        logic       d1_v;

        if (i == 0) begin : g_first
            assign nb_r   = '0;
            assign nb_r_v = 1'b0;
            assign ins_at[i] = ins_ge[i];
            assign rep_at[i] = !rep_lt[i];
        end else begin : g_mid
            assign nb_r   = slot[i-1];
            assign nb_r_v = vld[i-1];
            assign ins_at[i] = ins_ge[i] && !ins_ge[i-1];
            assign rep_at[i] = !rep_lt[i] && rep_lt[i-1];
        end

        if (i == DEPTH-1) begin : g_last
            assign nb_l   = '0;
            assign nb_l_v = 1'b0;
            assign rep_lt[i] = 1'b0;
        end else begin : g_inner
            assign nb_l   = slot[i+1];
            assign nb_l_v = vld[i+1];
            assign rep_lt[i] = vld[i+1] && (slot[i+1].key <= kvi.key);
        end

        // Strict less-than keeps equal keys in arrival order.
        assign ins_ge[i] = !vld[i] || (kvi.key < slot[i].key);

        always_comb begin
            sel      = 2'd0;
            dir_left = 1'b0;
            if (do_ins) begin
                if (ins_at[i])      sel = 2'd2;
                else if (ins_ge[i]) sel = 2'd1;
            end else if (do_del) begin
                sel      = 2'd1;
                dir_left = 1'b1;
            end else if (do_rep) begin
                dir_left = 1'b1;
                if (rep_lt[i])      sel = 2'd1;
                else if (rep_at[i]) sel = 2'd2;
            end
        end

        assign d1   = dir_left ? nb_l   : nb_r;
        assign d1_v = dir_left ? nb_l_v : nb_r_v;

        always_comb begin
            slot_d[i] = slot[i];
            vld_d[i]  = vld[i];
            case (sel)
                2'd1: begin
                    slot_d[i] = d1;
                    vld_d[i]  = d1_v;
                end
                2'd2, 2'd3: begin
                    slot_d[i] = kvi;
                    vld_d[i]  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
            vld   <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) slot[i] <= slot_d[i];
            vld   <= vld_d;
            ovf_q <= enq && !deq && is_full;
            udf_q <= deq && is_empty;
            if (do_ins)      cnt_q <= cnt_q + 1'b1;
            else if (do_del) cnt_q <= cnt_q - 1'b1;
        end
    end

    assign kvo       = slot[0];
    assign kvo_valid = vld[0];
    assign count     = cnt_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign ovf       = ovf_q;
    assign udf       = udf_q;
endmodule

// File: doc/ra_pq_regarray.md
# ra_pq_regarray

Register-array priority queue storage for the HWPQ study: a sorted array of `DEPTH` key-value slots (`kv_t` from `pq_pkg`) plus the per-slot select logic. It sits directly downstream of the per-slot 3-1 key-value mux (one instance per slot, sel encoding 0 = hold, 1 = neighbour shift, 2/3 = new item) and registers what that mux produces. It accepts enqueue and dequeue requests every cycle and always presents the minimum-key item at the head.

## Interface
- `DEPTH`, 8, number of slots (≥2)
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `enq`  in  1  insert `kvi` this cycle
- `kvi`  in  `kv_t`  item to insert (`key`, `value` fields)
- `deq`  in  1  remove current head (`kvo`) this cycle
- `kvo`  out  `kv_t`  head item (slot 0), registered
- `kvo_valid`  out  1  slot 0 holds an item
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `count`  out  `$clog2(DEPTH+1)`  items stored
- `ovf`  out  1  one-cycle pulse: enq dropped (full, no deq)
- `udf`  out  1  one-cycle pulse: deq ignored (empty)

## Operation
- State: `slot[0..DEPTH-1]` (`kv_t`), `vld[0..DEPTH-1]`, `count`. Invariant: valid slots contiguous from 0, keys non-decreasing with index; smaller key = higher priority.
- Each slot's next value comes from its mux: d0 = `slot[i]`, d1 = neighbour (`slot[i-1]` on enq-only, `slot[i+1]` on deq or enq+deq; 2:1 direction select ahead of d1), d2 = `kvi`. Out-of-range neighbours read as invalid.
- Enq only, not full: insertion point p = lowest i with `!vld[i]` or `kvi.key < slot[i].key` (strict: equal keys stay FIFO, new item behind). i<p sel 0; i==p sel 2; i>p sel 1 (shift right). count+1.
- Enq only, full: no state change, `ovf`=1 for one cycle.
- Deq only, not empty: every slot sel 1 (shift left); `vld[DEPTH-1]` cleared. count-1.
- Deq only, empty: no change, `udf`=1.
- Enq+deq, not empty (including full): replace head. q = number of valid slots j≥1 with `slot[j].key <= kvi.key`. i<q sel 1 (shift left); i==q sel 2; i>q sel 0. count unchanged; no ovf.
- Enq+deq, empty: deq ignored with `udf`=1; enq proceeds as enq-only (item lands in slot 0).
- Invalid slots' data is don't-care; `kvo` shows slot 0 data regardless, qualify with `kvo_valid`.
- `empty`, `full` decoded from registered `count`.

## Timing
- Reset (rst_n low at clock edge): all `vld`=0, all slots `'0`, count=0, `kvo`='0, `kvo_valid`=0, `empty`=1, `full`=0, `ovf`=0, `udf`=0. Reset wins over concurrent enq/deq; a reset mid-stream discards all contents.
- Enq at edge N: item visible in array (and at `kvo` if new minimum) after edge N; status outputs update same edge.
- Deq at edge N consumes the `kvo` value present before edge N; next head visible after edge N.
- Throughput: one enq, one deq, or one enq+deq per cycle, no stalls, no back-pressure; caller must observe `full`/`empty`.
- `ovf`/`udf` registered, high exactly one cycle per offending request.
- Insertion/position compares are combinational across all slots: one parallel compare per slot, thermometer-coded, in a single cycle.

## Test plan
- Reset then idle: `empty`=1, `count`=0, `kvo_valid`=0, `ovf`=`udf`=0; assert reset after partial fill (3 items) -> all cleared next cycle.
- DEPTH=4, enq keys 7,3,9,3' (distinct values) -> slots 3,3',7,9; `full`=1; four deqs return 3,3',7,9 in order, then `empty`=1.
- Full (keys 1,2,3,4), enq key 0 without deq -> `ovf` pulse, contents unchanged, `kvo.key`=1.
- Full (1,2,3,4), enq key 5 with deq -> `kvo.key`=1 consumed, array 2,3,4,5, count 4, no ovf; then enq key 0 with deq -> array 0,3,4,5.
- Empty, deq alone -> `udf` pulse, count 0; empty, enq key 6 with deq -> `udf` pulse, `kvo.key`=6, count 1.
- Random 10k-cycle enq/deq mix against a sorted-list model with stable tie order: `kvo`, `count`, `ovf`, `udf` match every cycle.
